// File: rtl/fm_audio_decimator.sv
// Integrate-and-dump decimator turning CORDIC instantaneous-frequency samples into
// saturated 16-bit audio, delivered through a single-entry valid/ready holding register.
module fm_audio_decimator #(
  parameter int DECIM      = 16,
  parameter int GAIN_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [17:0] f_inst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] audio,
  output logic               overrun
);

  localparam int ACC_W      = 24;
  localparam int CNT_W      = 6;
  localparam int LOG2_DECIM = $clog2(DECIM);

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = 24'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -24'sd32768;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] mean;
  logic signed [ACC_W-1:0] scaled;
  logic signed [15:0]      sat;
  logic [CNT_W-1:0]        cnt;
  logic                    dump;

  // Datapath for the dump: the sum includes the sample arriving this cycle, so the
  // DECIM-th sample never has to sit in the accumulator.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    sat    = '0;
    sum    = acc + ACC_W'($signed(f_inst));
    mean   = sum >>> LOG2_DECIM;
    scaled = mean >>> GAIN_SHIFT;
    dump   = in_valid && (cnt == CNT_LAST);

    if (scaled > SAT_MAX) begin
      sat = 16'sh7fff;
    end else if (scaled < SAT_MIN) begin
      sat = 16'sh8000;
    end else begin
      sat = scaled[15:0];
    end
  end

  // Accumulator and sample counter; both hold through in_valid gaps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (dump) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      acc <= sum;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Single-entry output register. A fresh result always wins; it flags overrun only
  // when it displaces a value the consumer has not taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      audio     <= '0;
      overrun   <= 1'b0;
    end else if (dump) begin
      audio     <= sat;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fm_audio_decimator.sv
// Scoreboard bench for fm_audio_decimator: two instances (GAIN_SHIFT 2 and 0) share
// the stimulus; expected audio comes from a floating-point floor/clamp model.
module tb_fm_audio_decimator;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [17:0] f_inst;
  logic               out_ready;
  logic               ov0, ov1, orn0, orn1;
  logic signed [15:0] au0, au1;

  int errors = 0;
  int checks = 0;
  int q0[$];
  int q1[$];
  int e0, e1;

  always #5 clk = ~clk;

  fm_audio_decimator #(.DECIM(16), .GAIN_SHIFT(2)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .f_inst(f_inst),
    .out_valid(ov0), .out_ready(out_ready), .audio(au0), .overrun(orn0)
  );

  fm_audio_decimator #(.DECIM(16), .GAIN_SHIFT(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .f_inst(f_inst),
    .out_valid(ov1), .out_ready(out_ready), .audio(au1), .overrun(orn1)
  );

  // Expected output: floor(sum / (16 * 2^g)) clamped to 16 bits.
  function automatic int model(input int sum, input int g);
    real d = 16.0;
    real r;
    int  v;
    for (int i = 0; i < g; i++) d = d * 2.0;
    r = $floor(real'(sum) / d);
    v = int'(r);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // Pops and compares on every transfer cycle.
  always @(negedge clk) begin
    if (!reset && out_ready) begin
      if (ov0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out0: audio=%0d while no result was due", au0);
        end else begin
          e0 = q0.pop_front();
          if (int'(au0) !== e0) begin
            errors++;
            $display("FAIL audio0: got %0d, expected %0d", au0, e0);
          end
        end
      end
      if (ov1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out1: audio=%0d while no result was due", au1);
        end else begin
          e1 = q1.pop_front();
          if (int'(au1) !== e1) begin
            errors++;
            $display("FAIL audio1: got %0d, expected %0d", au1, e1);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input int s);
    in_valid = 1'b1;
    f_inst   = 18'(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sum(input int sum);
    q0.push_back(model(sum, 2));
    q1.push_back(model(sum, 0));
  endtask

  // Constant-sample window; expected result queued just before the last sample.
  task automatic window(input int s, input bit push);
    for (int i = 0; i < 15; i++) send(s);
    if (push) push_sum(16 * s);
    send(s);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; f_inst = 18'sd5000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid0", int'(ov0), 0);
    chk("reset_audio0", int'(au0), 0);
    chk("reset_overrun0", int'(orn0), 0);
    chk("reset_valid1", int'(ov1), 0);
    chk("reset_audio1", int'(au1), 0);
    chk("reset_overrun1", int'(orn1), 0);
    reset = 1'b0; in_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    window(1000, 1'b1);
    chk("basic_latency_valid", int'(ov0), 1);
    chk("basic_overrun", int'(orn0), 0);
    idle(1);
    chk("basic_one_cycle_valid0", int'(ov0), 0);
    chk("basic_one_cycle_valid1", int'(ov1), 0);
  endtask

  task automatic test_floor();
    window(-3, 1'b1);
    idle(2);
  endtask

  task automatic test_saturate();
    window(131071, 1'b1);
    idle(1);
    window(-131072, 1'b1);
    idle(2);
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    window(400, 1'b0);
    chk("ovr_first_valid", int'(ov0), 1);
    chk("ovr_first_audio0", int'(au0), 100);
    chk("ovr_first_audio1", int'(au1), 400);
    chk("ovr_first_flag", int'(orn0), 0);
    idle(3);
    chk("ovr_hold_valid", int'(ov0), 1);
    chk("ovr_hold_audio", int'(au0), 100);
    window(800, 1'b0);
    chk("ovr_second_valid", int'(ov0), 1);
    chk("ovr_second_audio0", int'(au0), 200);
    chk("ovr_second_audio1", int'(au1), 800);
    chk("ovr_flag0", int'(orn0), 1);
    chk("ovr_flag1", int'(orn1), 1);
    q0.push_back(200);
    q1.push_back(800);
    out_ready = 1'b1;
    idle(1);
    chk("ovr_drain_valid", int'(ov0), 0);
    chk("ovr_sticky", int'(orn0), 1);
    idle(2);
    chk("ovr_sticky_later", int'(orn0), 1);
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push_sum(16000);
      send(1000);
      if (i < 15) begin
        chk("gaps_no_early_valid", int'(ov0), 0);
        idle(1);
      end
    end
    chk("gaps_valid", int'(ov0), 1);
    idle(1);
    chk("gaps_valid_clear", int'(ov0), 0);
  endtask

  task automatic test_reset_midwindow();
    for (int i = 0; i < 8; i++) send(4000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_overrun", int'(orn0), 0);
    chk("midrst_valid", int'(ov0), 0);
    window(400, 1'b1);
    chk("midrst_result_valid", int'(ov0), 1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int s, sum;
    for (int w = 0; w < 4; w++) begin
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        s = int'($urandom_range(0, 262143)) - 131072;
        sum += s;
        if (i == 15) push_sum(sum);
        send(s);
      end
    end
    idle(3);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; f_inst = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_floor();
    test_saturate();
    test_overrun();
    test_gaps();
    test_reset_midwindow();
    test_back_to_back();
    chk("scoreboard0_drained", q0.size(), 0);
    chk("scoreboard1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fm_audio_decimator.md
FM_AUDIO_DECIMATOR -- requirements
Module: fm_audio_decimator

Interface
REQ-001 Parameter DECIM, default 16, SHALL set the decimation ratio: samples averaged per output; legal values are powers of two, 2..64.
REQ-002 Parameter GAIN_SHIFT, default 2, SHALL set the arithmetic right shift applied to the mean before 16-bit saturation; legal values are 0..2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL qualify f_inst; a sample is consumed on every rising edge where in_valid=1.
REQ-006 f_inst  input  18  SHALL carry the signed two's-complement instantaneous-frequency sample from the CORDIC demodulator.
REQ-007 out_valid  output  1  SHALL indicate that audio holds an unconsumed result.
REQ-008 out_ready  input  1  SHALL indicate that the consumer accepts audio; a transfer occurs on an edge where out_valid=1 and out_ready=1.
REQ-009 audio  output  16  SHALL carry the signed decimated audio sample.
REQ-010 overrun  output  1  SHALL be a sticky flag indicating that an unconsumed result was overwritten.

Function
REQ-011 The block SHALL hold a signed accumulator of 24 bits (18 + log2(64)), so that no overflow occurs at any legal DECIM.
REQ-012 The block SHALL hold a sample counter that runs from 0 to DECIM-1, advances only on in_valid=1, and wraps to 0 after DECIM-1.
REQ-013 When in_valid=0, the accumulator and counter SHALL hold their values; gaps of any length SHALL be tolerated.
REQ-014 On an in_valid edge with counter < DECIM-1, the block SHALL set acc <= acc + sext(f_inst).
REQ-015 On an in_valid edge with counter = DECIM-1, the block SHALL form sum = acc + sext(f_inst), then mean = sum >>> log2(DECIM) (arithmetic shift, floor).
REQ-016 In the same dump cycle, the block SHALL form scaled = mean >>> GAIN_SHIFT and saturate it to [-32768, 32767].
REQ-017 In the same dump cycle, the saturated value SHALL be registered into audio, and the accumulator and counter SHALL be cleared to 0.
REQ-018 The window after a dump SHALL start with the next valid sample, with no sample lost or counted twice.
REQ-019 Latency: out_valid and the new audio value SHALL be visible in the cycle immediately after the edge that captured the DECIM-th sample.
REQ-020 The output stage SHALL be a single-entry holding register.
REQ-021 While out_valid=1 and out_ready=0, out_valid and audio SHALL remain stable until a new result arrives.
REQ-022 A transfer with no new result in the same cycle SHALL clear out_valid on the next edge.
REQ-023 A new result with (out_valid=0) or (out_valid=1 and out_ready=1) in the same cycle SHALL load audio, set out_valid=1, and leave overrun unchanged.
REQ-024 A new result with out_valid=1 and out_ready=0 SHALL overwrite audio with the newer value, keep out_valid=1, and set overrun=1.
REQ-025 Once set, overrun SHALL remain 1 until reset.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 While reset=1 at an edge, the block SHALL set acc=0, counter=0, out_valid=0, audio=0 and overrun=0.
REQ-028 While reset=1, the block SHALL ignore in_valid and out_ready.
REQ-029 Reset asserted mid-window SHALL discard the partial sum; the first valid sample after reset SHALL start a fresh window.
REQ-030 Reset SHALL take priority over a simultaneous dump or transfer.

Verification
REQ-031 DECIM=16, GAIN_SHIFT=2, out_ready=1, 16 consecutive samples f_inst=1000 -> out_valid=1 for exactly one cycle, the cycle after the 16th sample; audio=250; overrun=0.
REQ-032 16 samples f_inst=-3 -> sum=-48, mean=-3, audio=-1 (floor shift, not truncation toward zero).
REQ-033 GAIN_SHIFT=0, 16 samples f_inst=131071 -> audio=32767; then 16 samples f_inst=-131072 -> audio=-32768.
REQ-034 out_ready=0; window of 16 samples of 400, then window of 16 samples of 800 -> out_valid held high, audio=100 then 200, overrun=1; then out_ready=1 for one cycle -> out_valid=0 next cycle and overrun remains 1.
REQ-035 16 samples of 1000 delivered with in_valid toggling 1/0 every cycle -> exactly one result after the 16th valid sample; audio=250.
REQ-036 8 samples of 4000, reset for one cycle, then 16 samples of 400 -> audio=100; no result from the aborted window.
